// File: rtl/tap_tempo_pkg.sv
// Shared definitions for the tap-tempo meter: FSM state encoding, front-panel
// indicator codes, blink speed codes and the interval-to-speed classifier.
// No ports; imported by tap_tempo.
package tap_tempo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Indicator patterns shown for each state
    localparam logic [2:0] IND_IDLE   = 3'b000;
    localparam logic [2:0] IND_ARMED  = 3'b100;
    localparam logic [2:0] IND_LOCKED = 3'b010;

    // Speed codes: 0 slowest .. 3 fastest, matching the blinker's divider steps
    localparam logic [1:0] SPD_SLOWEST = 2'd0;
    localparam logic [1:0] SPD_SLOW    = 2'd1;
    localparam logic [1:0] SPD_FAST    = 2'd2;
    localparam logic [1:0] SPD_FASTEST = 2'd3;

    // Map an interval in cycles to a speed code. Boundaries sit at 2^B, 2^(B+1)
    // and 2^(B+2); longer intervals mean slower blinking.
    function automatic logic [1:0] speed_class(input logic [63:0] x,
                                               input int unsigned base_shift);
        logic [63:0] b0;
        logic [63:0] b1;
        logic [63:0] b2;
        b0 = 64'd1 << base_shift;
        b1 = b0 << 1;
        b2 = b0 << 2;
        if (x >= b2)
            return SPD_SLOWEST;
        else if (x >= b1)
            return SPD_SLOW;
        else if (x >= b0)
            return SPD_FAST;
        else
            return SPD_FASTEST;
    endfunction

    function automatic logic [2:0] state_indicator(input state_e s);
        case (s)
            ST_ARMED:  return IND_ARMED;
            ST_LOCKED: return IND_LOCKED;
            default:   return IND_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tap_tempo.sv
// Tap-tempo meter: measures the spacing of debounced tap pulses and derives the
// blinker's 2-bit speed code from the mean of the last two tap intervals.
// Ports: CLK/RST (sync, active-high), TAP in; SPEED, SPEED_VLD, INTERVAL,
//        TIMEOUT_P registered out; Indicator combinational from state.
module tap_tempo
    import tap_tempo_pkg::*;
#(
    parameter int unsigned CNT_W      = 28,  // must be >= BASE_SHIFT+3
    parameter int unsigned BASE_SHIFT = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TAP,
    output logic [1:0]       SPEED,
    output logic             SPEED_VLD,
    output logic [CNT_W-1:0] INTERVAL,
    output logic             TIMEOUT_P,
    output logic [2:0]       Indicator
);

    // Counter saturates here; a sequence silent this long is abandoned
    localparam logic [CNT_W-1:0] TIMEOUT = '1;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   prev_q;
    logic [1:0]         speed_q;
    logic               vld_q;
    logic [CNT_W-1:0]   interval_q;
    logic               timeout_q;

    logic               timed_out_d;
    logic [CNT_W:0]     sum_d;
    logic [CNT_W-1:0]   interval_d;
    logic [1:0]         speed_d;

    always_comb begin
        timed_out_d = (state_q != ST_IDLE) && (cnt_q == TIMEOUT);
        // One extra bit so two near-timeout intervals cannot overflow the sum
        sum_d       = {1'b0, prev_q} + {1'b0, cnt_q};
        // First interval of a sequence is reported as-is; later ones are
        // averaged with the previous raw interval
        interval_d  = (state_q == ST_LOCKED) ? CNT_W'(sum_d >> 1) : cnt_q;
        speed_d     = speed_class(64'(interval_d), BASE_SHIFT);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prev_q     <= '0;
            speed_q    <= SPD_SLOWEST;
            vld_q      <= 1'b0;
            interval_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            vld_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (TAP) begin
                        state_q <= ST_ARMED;
                        cnt_q   <= CNT_W'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                ST_ARMED, ST_LOCKED: begin
                    if (timed_out_d) begin
                        // Timeout takes priority over a coincident tap; that
                        // tap becomes the first of a fresh sequence.
                        timeout_q <= 1'b1;
                        if (TAP) begin
                            state_q <= ST_ARMED;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                        end
                    end else if (TAP) begin
                        state_q    <= ST_LOCKED;
                        prev_q     <= cnt_q;
                        interval_q <= interval_d;
                        speed_q    <= speed_d;
                        vld_q      <= 1'b1;
                        cnt_q      <= CNT_W'(1);
                    end else begin
                        // Cannot wrap: timeout fires at the all-ones value
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign SPEED     = speed_q;
    assign SPEED_VLD = vld_q;
    assign INTERVAL  = interval_q;
    assign TIMEOUT_P = timeout_q;
    assign Indicator = state_indicator(state_q);

endmodule
